// File: rtl/cdc_fifo_read_ctrl.sv
// Read-domain controller of the asynchronous FIFO.
// Converts the synchronized Gray write pointer to binary, issues RAM reads,
// holds the fetched word on a valid/ready output and returns a registered
// Gray read pointer toward the write domain. Fill level and a sticky
// pointer-consistency error flag are reported alongside.
module cdc_fifo_read_ctrl #(
  parameter int ADDR_BITWIDTH = 4,
  parameter int DATA_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     async_rst_n,
  input  logic [ADDR_BITWIDTH:0]   WritePtrGraySync,
  output logic [ADDR_BITWIDTH:0]   ReadPtrGray,
  output logic                     RdEn,
  output logic [ADDR_BITWIDTH-1:0] ReadAddr,
  input  logic [DATA_BITWIDTH-1:0] RAMReadData,
  output logic                     OutputValid,
  input  logic                     OutputReady,
  output logic [DATA_BITWIDTH-1:0] OutputData,
  output logic                     Empty,
  output logic [ADDR_BITWIDTH:0]   FillLevel,
  output logic                     PtrError
);

  localparam int PTR_W = ADDR_BITWIDTH + 1;

  // A fill of exactly 2**A is a legal full FIFO; anything above it cannot
  // come from a consistent pair of pointers.
  localparam logic [PTR_W-1:0] FULL_LEVEL = {1'b1, {ADDR_BITWIDTH{1'b0}}};
  localparam logic [PTR_W-1:0] PTR_ONE    = {{ADDR_BITWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] gray);
    logic [PTR_W-1:0] bin;
    bin[PTR_W-1] = gray[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Binary to Gray: adjacent values differ in exactly one bit.
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  state_t                   state_r;
  state_t                   state_next_s;
  logic [PTR_W-1:0]         rd_ptr_bin_r;
  logic [PTR_W-1:0]         rd_ptr_gray_r;
  logic [PTR_W-1:0]         rd_ptr_next_s;
  logic [PTR_W-1:0]         wr_ptr_bin_s;
  logic [PTR_W-1:0]         raw_diff_s;
  logic [PTR_W-1:0]         fill_next_s;
  logic [PTR_W-1:0]         fill_r;
  logic                     empty_s;
  logic                     rd_en_s;
  logic                     data_load_s;
  logic                     valid_next_s;
  logic                     out_valid_r;
  logic [DATA_BITWIDTH-1:0] out_data_r;
  logic                     ptr_err_r;
  logic                     ptr_err_next_s;

  assign wr_ptr_bin_s = gray2bin(WritePtrGraySync);
  assign empty_s      = (wr_ptr_bin_s == rd_ptr_bin_r);
  assign raw_diff_s   = wr_ptr_bin_s - rd_ptr_bin_r;

  // FSM next state, RAM read strobe, output-valid and data-capture decisions.
  always_comb begin
    state_next_s = state_r;
    rd_en_s      = 1'b0;
    data_load_s  = 1'b0;
    valid_next_s = out_valid_r;
    case (state_r)
      ST_IDLE: begin
        valid_next_s = 1'b0;
        if (!empty_s) begin
          rd_en_s      = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // RAM data for the read issued last cycle is on RAMReadData now.
        data_load_s  = 1'b1;
        valid_next_s = 1'b1;
        state_next_s = ST_VALID;
      end
      ST_VALID: begin
        valid_next_s = 1'b1;
        if (OutputReady) begin
          valid_next_s = 1'b0;
          if (!empty_s) begin
            rd_en_s      = 1'b1;
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_VALID;
        end
      end
      default: begin
        valid_next_s = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next read pointer, fill level and sticky error evaluation.
  always_comb begin
    if (rd_en_s) begin
      rd_ptr_next_s = rd_ptr_bin_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_bin_r;
    end
    fill_next_s    = wr_ptr_bin_s - rd_ptr_next_s;
    ptr_err_next_s = ptr_err_r | (raw_diff_s > FULL_LEVEL);
  end

  // State, pointers, output word and status registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_r       <= ST_IDLE;
      rd_ptr_bin_r  <= {PTR_W{1'b0}};
      rd_ptr_gray_r <= {PTR_W{1'b0}};
      out_valid_r   <= 1'b0;
      out_data_r    <= {DATA_BITWIDTH{1'b0}};
      fill_r        <= {PTR_W{1'b0}};
      ptr_err_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      rd_ptr_bin_r  <= rd_ptr_next_s;
      rd_ptr_gray_r <= bin2gray(rd_ptr_next_s);
      out_valid_r   <= valid_next_s;
      fill_r        <= fill_next_s;
      ptr_err_r     <= ptr_err_next_s;
      if (data_load_s) begin
        out_data_r <= RAMReadData;
      end else begin
        out_data_r <= out_data_r;
      end
    end
  end

  assign ReadPtrGray = rd_ptr_gray_r;
  assign RdEn        = rd_en_s;
  assign ReadAddr    = rd_ptr_bin_r[ADDR_BITWIDTH-1:0];
  assign OutputValid = out_valid_r;
  assign OutputData  = out_data_r;
  assign Empty       = empty_s;
  assign FillLevel   = fill_r;
  assign PtrError    = ptr_err_r;

endmodule
